// File: rtl/tff_mod_counter.sv
// rtl/tff_mod_counter.sv - modulo-N up/down counter built from per-bit toggle flip-flops
// Each q bit only flips where t_vec is set, so t_vec doubles as the observable toggle plan.
module tff_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic [WIDTH-1:0] t_vec,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] t_chain;
    logic             tc_q;
    logic             tc_d;

    // Ripple toggle chain: bit i toggles when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        logic carry;
        carry   = 1'b1;
        t_chain = '0;
        for (int i = 0; i < WIDTH; i++) begin
            t_chain[i] = carry;
            carry      = carry & (up ? q_q[i] : ~q_q[i]);
        end
    end

    always_comb begin
        q_d  = q_q;
        tc_d = 1'b0;
        if (load) begin
            q_d = ({1'b0, din} >= MOD_EXT) ? MAX_VAL : din;
        end else if (en) begin
            if (up && (q_q == MAX_VAL)) begin
                q_d  = '0;
                tc_d = 1'b1;
            end else if (!up && (q_q == '0)) begin
                q_d  = MAX_VAL;
                tc_d = 1'b1;
            end else begin
                q_d = q_q ^ t_chain;
            end
        end
        t_vec = q_q ^ q_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q  <= '0;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_q ^ t_vec;
            tc_q <= tc_d;
        end
    end

    assign q  = q_q;
    assign qb = ~q_q;
    assign tc = tc_q;

endmodule

// File: tb/tb_tff_mod_counter.sv
// tb/tb_tff_mod_counter.sv - scoreboard bench for tff_mod_counter (10-count and 8-count instances)
module tb_tff_mod_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       en_a, up_a, load_a, tc_a;
    logic [3:0] din_a, q_a, qb_a, t_vec_a;
    logic       en_b, up_b, load_b, tc_b;
    logic [2:0] din_b, q_b, qb_b, t_vec_b;

    tff_mod_counter u_dut_a (
        .clk(clk), .reset(reset), .en(en_a), .up(up_a), .load(load_a), .din(din_a),
        .q(q_a), .qb(qb_a), .t_vec(t_vec_a), .tc(tc_a)
    );

    tff_mod_counter #(.WIDTH(3), .MODULUS(8)) u_dut_b (
        .clk(clk), .reset(reset), .en(en_b), .up(up_b), .load(load_b), .din(din_b),
        .q(q_b), .qb(qb_b), .t_vec(t_vec_b), .tc(tc_b)
    );

    typedef struct {
        int    sel;
        int    q;
        logic  tc;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   mq_a  = 0;
    int   mq_b  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic zero_inputs();
        en_a = 1'b0; up_a = 1'b0; load_a = 1'b0; din_a = '0;
        en_b = 1'b0; up_b = 1'b0; load_b = 1'b0; din_b = '0;
    endtask

    task automatic step(input int sel, input logic e, input logic u, input logic l,
                        input int d, input string tag);
        int          modv, mask, cur, nxt;
        logic        tcn;
        exp_t        ex;
        logic [31:0] tv, qo, qbo, tco;
        modv = (sel == 0) ? 10 : 8;
        mask = (sel == 0) ? 15 : 7;
        if (sel == 0) begin
            en_a = e; up_a = u; load_a = l; din_a = 4'(d);
            cur  = mq_a;
        end else begin
            en_b = e; up_b = u; load_b = l; din_b = 3'(d);
            cur  = mq_b;
        end
        #1;
        nxt = cur;
        tcn = 1'b0;
        if (l) begin
            nxt = (d >= modv) ? modv - 1 : d;
        end else if (e) begin
            if (u) begin
                if (cur == modv - 1) begin nxt = 0; tcn = 1'b1; end
                else nxt = cur + 1;
            end else begin
                if (cur == 0) begin nxt = modv - 1; tcn = 1'b1; end
                else nxt = cur - 1;
            end
        end
        tv = (sel == 0) ? 32'(t_vec_a) : 32'(t_vec_b);
        chk({tag, ".t_vec"}, tv, 32'((cur ^ nxt) & mask));
        ex.sel = sel; ex.q = nxt; ex.tc = tcn; ex.tag = tag;
        sb.push_back(ex);

        @(posedge clk);
        #1;
        ex = sb.pop_front();
        if (ex.sel == 0) begin
            qo = 32'(q_a); qbo = 32'(qb_a); tco = 32'(tc_a);
            mq_a = ex.q;
        end else begin
            qo = 32'(q_b); qbo = 32'(qb_b); tco = 32'(tc_b);
            mq_b = ex.q;
        end
        chk({ex.tag, ".q"}, qo, 32'(ex.q));
        chk({ex.tag, ".qb"}, qbo, 32'(~ex.q & mask));
        chk({ex.tag, ".tc"}, tco, 32'(ex.tc));
        zero_inputs();
    endtask

    // Expects reset already high; verifies outputs, that strobes are ignored, then releases.
    task automatic hold_in_reset(input string tag);
        chk({tag, ".q_a"}, 32'(q_a), 32'd0);
        chk({tag, ".qb_a"}, 32'(qb_a), 32'hF);
        chk({tag, ".tc_a"}, 32'(tc_a), 32'd0);
        chk({tag, ".q_b"}, 32'(q_b), 32'd0);
        chk({tag, ".qb_b"}, 32'(qb_b), 32'h7);
        chk({tag, ".tc_b"}, 32'(tc_b), 32'd0);
        en_a = 1'b1; up_a = 1'b1; load_a = 1'b1; din_a = 4'd6;
        en_b = 1'b1; up_b = 1'b1; load_b = 1'b1; din_b = 3'd5;
        repeat (2) @(posedge clk);
        #1;
        chk({tag, ".held_q_a"}, 32'(q_a), 32'd0);
        chk({tag, ".held_q_b"}, 32'(q_b), 32'd0);
        chk({tag, ".held_tc_a"}, 32'(tc_a), 32'd0);
        zero_inputs();
        @(negedge clk);
        reset = 1'b0;
        mq_a = 0;
        mq_b = 0;
    endtask

    task automatic mid_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        hold_in_reset(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        zero_inputs();
        #1;
        hold_in_reset("por");

        for (int i = 0; i < 12; i++) step(0, 1'b1, 1'b1, 1'b0, 0, "up_seq");

        step(0, 1'b0, 1'b0, 1'b1, 0, "load0");
        for (int i = 0; i < 3; i++) step(0, 1'b1, 1'b0, 1'b0, 0, "down_seq");

        mid_reset("mid_rst_q7");
        step(0, 1'b1, 1'b0, 1'b0, 0, "rel_down");

        step(0, 1'b0, 1'b0, 1'b1, 8, "load8");
        step(0, 1'b1, 1'b1, 1'b0, 0, "up_to9");
        step(0, 1'b1, 1'b1, 1'b0, 0, "wrap_tc");
        mid_reset("rst_kills_tc");

        step(0, 1'b0, 1'b0, 1'b1, 13, "clamp13");
        step(0, 1'b1, 1'b1, 1'b1, 3, "load_wins");
        step(0, 1'b1, 1'b1, 1'b1, 9, "load_bound9");
        step(0, 1'b1, 1'b1, 1'b1, 0, "load_at_top");
        step(0, 1'b0, 1'b0, 1'b1, 15, "clamp15");

        step(0, 1'b0, 1'b0, 1'b1, 5, "load5");
        for (int i = 0; i < 5; i++) step(0, 1'b0, 1'b1, 1'b0, 0, "hold");
        step(0, 1'b1, 1'b1, 1'b0, 0, "dir_up");
        step(0, 1'b1, 1'b0, 1'b0, 0, "dir_down");
        step(0, 1'b1, 1'b1, 1'b0, 0, "dir_up2");

        step(1, 1'b0, 1'b0, 1'b1, 5, "b_load5");
        for (int i = 0; i < 4; i++) step(1, 1'b1, 1'b1, 1'b0, 0, "b_up");
        for (int i = 0; i < 3; i++) step(1, 1'b1, 1'b0, 1'b0, 0, "b_down");
        step(1, 1'b1, 1'b1, 1'b0, 0, "b_up_wrap");

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tff_mod_counter.md
TFF_MOD_COUNTER -- requirements
Module: tff_mod_counter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, giving the counter width in bits.
REQ-002 The module SHALL have parameter MODULUS, default 10, giving the count length; legal range 2 to 2^WIDTH.
REQ-003 Port clk SHALL be an input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit, asynchronous and active-high.
REQ-005 Port en SHALL be an input, 1 bit, the count enable.
REQ-006 Port up SHALL be an input, 1 bit: 1 = count up, 0 = count down.
REQ-007 Port load SHALL be an input, 1 bit, the synchronous load strobe.
REQ-008 Port din SHALL be an input, WIDTH bits, the load value.
REQ-009 Port q SHALL be an output, WIDTH bits, the registered count.
REQ-010 Port qb SHALL be an output, WIDTH bits, always equal to ~q.
REQ-011 Port t_vec SHALL be an output, WIDTH bits, the per-bit toggle enables applied at the next edge.
REQ-012 Port tc SHALL be an output, 1 bit, a registered one-cycle pulse on wrap.

Function
REQ-013 Each bit of q SHALL be held in a T-type storage element: q[i] toggles at a rising edge if and only if t_vec[i]=1.
REQ-014 t_vec SHALL be combinational and equal q XOR next_q, so that t_vec is all-zero whenever q will not change.
REQ-015 Up count, non-wrap, SHALL follow the T-FF chain rule: t_vec[0]=1, and t_vec[i] = AND of q[0..i-1] for i>0.
REQ-016 Down count, non-wrap, SHALL follow the chain rule: t_vec[0]=1, and t_vec[i] = AND of ~q[0..i-1] for i>0.
REQ-017 Up wrap SHALL apply: when en=1, up=1 and q=MODULUS-1, next q = 0.
REQ-018 Down wrap SHALL apply: when en=1, up=0 and q=0, next q = MODULUS-1.
REQ-019 Priority SHALL be load over en: load=1 sets next q from din regardless of en and up.
REQ-020 Load clamp: if din >= MODULUS, next q SHALL be MODULUS-1.
REQ-021 Hold: with en=0 and load=0, q SHALL be unchanged and t_vec SHALL be 0.
REQ-022 tc SHALL be 1 for exactly the one cycle after an edge at which a wrap occurred (REQ-017 or REQ-018); otherwise tc SHALL be 0.
REQ-023 A load SHALL NOT assert tc, even when the loaded value equals a wrap boundary.
REQ-024 Counting latency SHALL be one cycle: the q update is visible after the edge at which en was sampled high.
REQ-025 With MODULUS = 2^WIDTH, the wrap SHALL equal natural binary overflow.
REQ-026 When up changes mid-count, the new direction SHALL take effect at the next edge with no extra cycle.

Reset
REQ-027 Assertion of reset SHALL immediately, without waiting for clk, force q=0, qb=all ones and tc=0.
REQ-028 While reset is high, q SHALL be held at 0 and en/load SHALL be ignored.
REQ-029 On reset release, the first counting edge SHALL move q from 0 to 1 (up) or to MODULUS-1 (down, with a tc pulse).
REQ-030 Reset asserted between edges during a wrap cycle SHALL suppress the pending tc.

Verification
REQ-031 The bench SHALL cover this scenario: reset=1 mid-cycle with q=7 -> q=0, qb=4'b1111, tc=0 before the next clk edge.
REQ-032 The bench SHALL cover this scenario: defaults, en=1, up=1, 12 edges from 0 -> q sequence 1..9, 0, 1, 2, with tc high for exactly one cycle after the 9->0 edge.
REQ-033 The bench SHALL cover this scenario: en=1, up=0 from q=0 -> q=9 and tc pulses, then 8, 7; t_vec=4'b1001 at q=0 (0->9) and 4'b0001 at q=9 (9->8).
REQ-034 The bench SHALL cover this scenario: load=1, din=13 -> q=9, tc=0; then load=1, en=1, din=3 -> q=3 (load wins).
REQ-035 The bench SHALL cover this scenario: en=0 for 5 edges at q=5 -> q stays 5, t_vec=0, tc=0; then toggle up each cycle -> 6, 5, 6.
REQ-036 The bench SHALL cover this scenario: WIDTH=3, MODULUS=8, up count -> 7->0 wrap with t_vec=3'b111 and one tc pulse; qb checked against ~q on every cycle.
